// File: rtl/wf_neopixel_drv.sv
// Serial driver for WS2812B/SK6805-class LED chains: fetches pixels from a synchronous
// RAM, shifts them out MSB-first as timed pulses, then holds the line low to latch.
module wf_neopixel_drv #(
  parameter int NUM_PIXELS = 8,
  parameter int ADDR_W     = 8,
  parameter int PIXEL_BITS = 24,
  parameter int T_PERIOD   = 15,
  parameter int T1_HI      = 10,
  parameter int T0_HI      = 5,
  parameter int RESET_CLKS = 600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  // auto-repeat request; 'repeat' itself is a reserved word
  input  logic                  repeat_en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIXEL_BITS-1:0] rd_data,
  output logic                  dout
);

  localparam int TW = $clog2(T_PERIOD);
  localparam int BW = $clog2(PIXEL_BITS);
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int LW = $clog2(RESET_CLKS + 1);

  generate
    if (NUM_PIXELS < 1 || ADDR_W < 1 || ADDR_W > 30 || NUM_PIXELS > (1 << ADDR_W) ||
        (PIXEL_BITS != 24 && PIXEL_BITS != 32) || T_PERIOD < 3 ||
        T1_HI < 1 || T1_HI >= T_PERIOD || T0_HI < 1 || T0_HI >= T_PERIOD ||
        T0_HI == T1_HI || RESET_CLKS < 1) begin : g_bad_params
      $error("wf_neopixel_drv: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_LATCH} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         t_cnt_q, t_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]         lat_cnt_q, lat_cnt_d;
  logic [PIXEL_BITS-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  // set only for a latch that follows a real frame, so the post-reset latch stays silent
  logic                  framed_q, framed_d;
  logic [TW-1:0]         hi_last;

  assign hi_last = shift_q[PIXEL_BITS-1] ? TW'(T1_HI - 1) : TW'(T0_HI - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_LATCH;
      t_cnt_q   <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      lat_cnt_q <= '0;
      shift_q   <= '0;
      rd_addr_q <= '0;
      dout_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      framed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_cnt_q   <= t_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      shift_q   <= shift_d;
      rd_addr_q <= rd_addr_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      framed_q  <= framed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t_cnt_d   = t_cnt_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    lat_cnt_d = lat_cnt_q;
    shift_d   = shift_q;
    rd_addr_d = rd_addr_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    framed_d  = framed_q;
    case (state_q)
      ST_IDLE: begin
        dout_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          rd_addr_d = '0;
          busy_d    = 1'b1;
          t_cnt_d   = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (t_cnt_q == TW'(1)) begin
          shift_d   = rd_data;
          dout_d    = 1'b1;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          t_cnt_d   = '0;
          if (NUM_PIXELS > 1) rd_addr_d = ADDR_W'(1);
          state_d   = ST_SEND;
        end else begin
          t_cnt_d = t_cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (t_cnt_q == TW'(T_PERIOD - 1)) begin
          t_cnt_d = '0;
          if (bit_cnt_q != BW'(PIXEL_BITS - 1)) begin
            shift_d   = {shift_q[PIXEL_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            dout_d    = 1'b1;
          end else if (pix_cnt_q != PW'(NUM_PIXELS - 1)) begin
            // rd_data already holds the next pixel, prefetched one pixel ahead
            shift_d   = rd_data;
            pix_cnt_d = pix_cnt_q + 1'b1;
            bit_cnt_d = '0;
            dout_d    = 1'b1;
            if (32'(pix_cnt_q) + 32'd2 < 32'(NUM_PIXELS))
              rd_addr_d = ADDR_W'(32'(pix_cnt_q) + 32'd2);
          end else begin
            dout_d    = 1'b0;
            lat_cnt_d = '0;
            framed_d  = 1'b1;
            state_d   = ST_LATCH;
          end
        end else begin
          t_cnt_d = t_cnt_q + 1'b1;
          if (t_cnt_q == hi_last) dout_d = 1'b0;
        end
      end
      ST_LATCH: begin
        dout_d = 1'b0;
        if (lat_cnt_q == LW'(RESET_CLKS - 1)) begin
          lat_cnt_d = '0;
          framed_d  = 1'b0;
          done_d    = framed_q;
          if (framed_q && repeat_en) begin
            rd_addr_d = '0;
            t_cnt_d   = '0;
            state_d   = ST_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_addr = rd_addr_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_wf_neopixel_drv.sv
// Self-checking bench: random pixel RAM contents, expected waveform built from the
// pulse-width rules per bit, frame/latch timing and handshake checked per frame.
module tb_wf_neopixel_drv;
  localparam int NP = 3;
  localparam int AW = 8;
  localparam int PB = 24;
  localparam int TP = 15;
  localparam int T1 = 10;
  localparam int T0 = 5;
  localparam int RC = 600;
  localparam int NBT = NP * PB * TP;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rpt;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [PB-1:0] rd_data;
  logic          dout;

  logic [PB-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  wf_neopixel_drv #(
    .NUM_PIXELS(NP), .ADDR_W(AW), .PIXEL_BITS(PB), .T_PERIOD(TP),
    .T1_HI(T1), .T0_HI(T0), .RESET_CLKS(RC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .repeat_en(rpt), .busy(busy),
    .done(done), .rd_addr(rd_addr), .rd_data(rd_data), .dout(dout)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < NP; a++) mem[a] = PB'($urandom);
  endtask

  // Counts clocks of the latch that follows reset release; called on the release negedge.
  task automatic post_reset_latch(input string tag);
    int cnt, dn, hi;
    cnt = 0; dn = 0; hi = 0;
    while (busy === 1'b1 && cnt < RC + 20) begin
      if (done === 1'b1) dn++;
      if (dout !== 1'b0) hi++;
      cnt++;
      tick();
    end
    check_eq({tag, "_len"}, 64'(cnt), 64'(RC));
    check_eq({tag, "_done"}, 64'(dn), 64'd0);
    check_eq({tag, "_dout"}, 64'(hi), 64'd0);
    $display("post-reset latch %s: busy high %0d clocks", tag, cnt);
  endtask

  // Entered on the negedge right after the accepting edge; returns on the done cycle.
  task automatic frame_check(input int fno, input bit rep, input bit poke);
    logic [PB-1:0] exp_px [NP];
    logic [PB-1:0] obs_px [NP];
    logic [63:0]   seq_obs, seq_exp;
    logic [AW-1:0] prev_addr;
    int            mism, busy_drop, lat, lat_hi, highs, p, b, ph;
    logic          exp_lvl;
    for (int i = 0; i < NP; i++) begin
      exp_px[i] = mem[i];
      obs_px[i] = '0;
    end
    check_eq("busy_acc", 64'(busy), 64'd1);
    seq_obs = 64'(rd_addr) + 64'd1;
    prev_addr = rd_addr;
    seq_exp = 0;
    for (int i = 0; i < NP; i++) seq_exp = (seq_exp << 4) + 64'(i + 1);
    tick();
    check_eq("done_1clk", 64'(done), 64'd0);
    check_eq("load_lo", 64'(dout), 64'd0);
    mism = 0; busy_drop = 0; highs = 0;
    for (int i = 0; i < NBT; i++) begin
      if (poke) start = (i == NBT / 2);
      tick();
      p  = i / (PB * TP);
      b  = (i / TP) % PB;
      ph = i % TP;
      exp_lvl = (ph < (exp_px[p][PB-1-b] ? T1 : T0));
      if (dout !== exp_lvl) mism++;
      if (dout === 1'b1) highs++;
      if (ph == TP - 1) begin
        obs_px[p] = {obs_px[p][PB-2:0], (2 * highs > T0 + T1)};
        highs = 0;
      end
      if (busy !== 1'b1) busy_drop++;
      if (rd_addr !== prev_addr) begin
        seq_obs = (seq_obs << 4) + 64'(rd_addr) + 64'd1;
        prev_addr = rd_addr;
      end
    end
    start = 1'b0;
    lat = 0; lat_hi = 0;
    tick();
    while (done !== 1'b1 && lat < RC + 20) begin
      if (poke) start = (lat == RC / 2);
      if (rep && lat == 1) randomize_mem();
      if (dout !== 1'b0) lat_hi++;
      lat++;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < NP; i++) check_eq($sformatf("pix%0d", i), 64'(obs_px[i]), 64'(exp_px[i]));
    check_eq("wave_shape", 64'(mism), 64'd0);
    check_eq("busy_frame", 64'(busy_drop), 64'd0);
    check_eq("addr_seq", seq_obs, seq_exp);
    check_eq("latch_len", 64'(lat), 64'(RC));
    check_eq("latch_dout", 64'(lat_hi), 64'd0);
    check_eq("busy_done", 64'(busy), 64'(rep));
    check_eq("addr_end", 64'(rd_addr), rep ? 64'd0 : 64'(NP - 1));
    $display("frame %0d rep=%0d poke=%0d px0=%h px1=%h px2=%h wave_err=%0d latch=%0d",
             fno, rep, poke, exp_px[0], exp_px[1], exp_px[2], mism, lat);
  endtask

  initial begin
    int idle_busy, idle_hi, found;
    reset = 1'b1; start = 1'b0; rpt = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    repeat (3) tick();
    check_eq("rst_dout", 64'(dout), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_addr", 64'(rd_addr), 64'd0);
    reset = 1'b0;
    post_reset_latch("prl");

    // directed pattern: MSB/LSB ones, all-zero pixel, mixed pixel
    mem[0] = 24'h800001; mem[1] = 24'h000000; mem[2] = 24'hA5C33C;
    start = 1'b1; tick(); start = 1'b0;
    frame_check(1, 1'b0, 1'b0);

    // starts during SEND and LATCH must be ignored; a start on the done cycle is taken
    randomize_mem();
    start = 1'b1; tick(); start = 1'b0;
    frame_check(2, 1'b0, 1'b1);
    randomize_mem();
    start = 1'b1; tick(); start = 1'b0;
    frame_check(3, 1'b0, 1'b0);
    idle_busy = 0; idle_hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy !== 1'b0) idle_busy++;
      if (dout !== 1'b0) idle_hi++;
    end
    check_eq("no_extra_busy", 64'(idle_busy), 64'd0);
    check_eq("no_extra_dout", 64'(idle_hi), 64'd0);

    // free-running frames
    randomize_mem();
    rpt = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    frame_check(4, 1'b1, 1'b0);
    frame_check(5, 1'b1, 1'b0);
    rpt = 1'b0;
    frame_check(6, 1'b0, 1'b0);

    // reset while dout is high mid-pixel
    randomize_mem();
    mem[1] = 24'hFFFFFF;
    start = 1'b1; tick(); start = 1'b0;
    repeat (PB * TP + 40) tick();
    found = 0;
    for (int i = 0; i < 2 * TP && found == 0; i++) begin
      if (dout === 1'b1) found = 1;
      else tick();
    end
    check_eq("mid_high_found", 64'(found), 64'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("async_dout", 64'(dout), 64'd0);
    check_eq("async_busy", 64'(busy), 64'd1);
    repeat (2) tick();
    reset = 1'b0;
    start = 1'b1;
    post_reset_latch("prl2");
    tick(); start = 1'b0;
    frame_check(7, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
